// File: rtl/lane_step_scheduler.sv
// -----------------------------------------------------------------------------
// lane_step_scheduler
//
// Turns the prescaled game tick into per-lane "advance this lane" requests and
// hands them, one lane at a time, to the car-position datapath over a
// valid/ready port. It also owns the game-run FSM (IDLE/RUN/PAUSE/OVER), which
// gates all movement.
//
// Each lane i has a base period (in base ticks) that shrinks by STEP_DEC per
// level, with a floor of MIN_PERIOD. A lane that comes due while its previous
// step is still waiting is merged into the existing request, and the sticky
// o_Overrun flag is raised.
//
// Optional feature: define LANE_SCHED_JITTER_EN to add 0/+1 base tick of
// LFSR-driven jitter to every lane reload. Left undefined, the schedule is
// fully deterministic.
//
// Ports
//   i_Clk         system clock
//   i_Rst_L       asynchronous active-low reset
//   i_Start       pulse, IDLE/OVER -> RUN (restarts the game)
//   i_Pause       level, hold in PAUSE while high
//   i_Level_Up    pulse, level + 1 (saturating), RUN/PAUSE only
//   i_Game_Over   pulse, RUN/PAUSE -> OVER
//   i_Step_Ready  datapath accepts the presented step
//   o_Step_Valid  step request for o_Step_Lane
//   o_Step_Lane   lane to advance
//   o_Level       current level
//   o_State       0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
//   o_Overrun     sticky, a lane came due while its step was still pending
// -----------------------------------------------------------------------------
module lane_step_scheduler #(
  parameter int NUM_LANES = 10,
  parameter int PRESCALE  = 250000,
  parameter int PERIOD_W  = 8,
  parameter logic [NUM_LANES*PERIOD_W-1:0] c_BASE_PERIOD = {NUM_LANES{8'd20}},
  parameter int LEVEL_W    = 3,
  parameter int STEP_DEC   = 2,
  parameter int MIN_PERIOD = 1,
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Start,
  input  logic               i_Pause,
  input  logic               i_Level_Up,
  input  logic               i_Game_Over,
  input  logic               i_Step_Ready,
  output logic               o_Step_Valid,
  output logic [LANE_W-1:0]  o_Step_Lane,
  output logic [LEVEL_W-1:0] o_Level,
  output logic [1:0]         o_State,
  output logic               o_Overrun
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SUM_W   = PERIOD_W + LEVEL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [LEVEL_W-1:0]   level_reg, level_next;
  logic [NUM_LANES-1:0] pending_reg, pending_next;
  logic [NUM_LANES-1:0] lane_ovr;
  logic [LANE_W-1:0]    ptr_reg, ptr_next;
  logic                 valid_reg, valid_next;
  logic [LANE_W-1:0]    lane_reg, lane_next;
  logic                 overrun_reg, overrun_next;
  logic [PERIOD_W-1:0]  jitter_add;

  logic start_evt, over_evt, base_tick, accept, grant_ok, level_up_ok;
  logic is_run, is_run_or_pause, is_idle_or_over;

  // Effective lane period: base minus the level discount, floored at
  // MIN_PERIOD. The subtraction is guarded so it can never wrap.
  function automatic logic [PERIOD_W-1:0] eff_of(input logic [PERIOD_W-1:0] base,
                                                 input logic [LEVEL_W-1:0]  lvl);
    logic [SUM_W-1:0] base_ext;
    logic [SUM_W-1:0] dec;
    logic [SUM_W-1:0] diff;
    base_ext = SUM_W'(base);
    dec      = SUM_W'(lvl) * SUM_W'(STEP_DEC);
    diff     = (base_ext > dec) ? (base_ext - dec) : '0;
    if (diff < SUM_W'(MIN_PERIOD)) diff = SUM_W'(MIN_PERIOD);
    return PERIOD_W'(diff);
  endfunction

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign is_run          = (state_reg == ST_RUN);
  assign is_run_or_pause = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);
  assign is_idle_or_over = (state_reg == ST_IDLE) || (state_reg == ST_OVER);

  // Game_Over outranks Start, so a simultaneous pair never restarts.
  assign over_evt    = i_Game_Over && is_run_or_pause;
  assign start_evt   = i_Start && !i_Game_Over && is_idle_or_over;
  assign level_up_ok = i_Level_Up && is_run_or_pause;
  assign base_tick   = is_run && (presc_reg == PRESC_W'(PRESCALE - 1));
  assign accept      = valid_reg && i_Step_Ready;

  // ---------------------------------------------------------------------------
  // Game-run FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_evt) state_next = ST_RUN;
      ST_RUN: begin
        if (over_evt)     state_next = ST_OVER;
        else if (i_Pause) state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (over_evt)      state_next = ST_OVER;
        else if (!i_Pause) state_next = ST_RUN;
      end
      ST_OVER:  if (start_evt) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler (runs only in RUN, frozen otherwise) and level
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_next = presc_reg;
    if (start_evt)      presc_next = '0;
    else if (base_tick) presc_next = '0;
    else if (is_run)    presc_next = presc_reg + PRESC_W'(1);
  end

  always_comb begin
    level_next = level_reg;
    if (start_evt)                          level_next = '0;
    else if (level_up_ok && level_reg != '1) level_next = level_reg + LEVEL_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Reload jitter
  // ---------------------------------------------------------------------------
`ifdef LANE_SCHED_JITTER_EN
  logic [7:0] lfsr_reg, lfsr_next;
  logic       lfsr_fb;

  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1.
  assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

  always_comb begin
    lfsr_next = lfsr_reg;
    if (start_evt)      lfsr_next = 8'hA5;
    else if (base_tick) lfsr_next = {lfsr_reg[6:0], lfsr_fb};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) lfsr_reg <= 8'hA5;
    else          lfsr_reg <= lfsr_next;
  end

  // A reload uses the LFSR value from before this tick's shift.
  assign jitter_add = PERIOD_W'(lfsr_reg[0]);
`else
  assign jitter_add = '0;
`endif

  // ---------------------------------------------------------------------------
  // Per-lane period counters and pending bits
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [PERIOD_W-1:0] BASE_P = c_BASE_PERIOD[gi*PERIOD_W +: PERIOD_W];

      logic [PERIOD_W-1:0] cnt_reg, cnt_next;
      logic [PERIOD_W-1:0] start_load, reload_val;
      logic                fire, clr;

      // A level change only takes effect at the lane's next reload.
      assign start_load = eff_of(BASE_P, '0) - PERIOD_W'(1);
      assign reload_val = eff_of(BASE_P, level_reg) - PERIOD_W'(1) + jitter_add;
      assign fire       = base_tick && (cnt_reg == '0);
      assign clr        = accept && (lane_reg == LANE_W'(gi));

      always_comb begin
        cnt_next = cnt_reg;
        if (start_evt)      cnt_next = start_load;
        else if (base_tick) cnt_next = fire ? reload_val : (cnt_reg - PERIOD_W'(1));
      end

      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) cnt_reg <= '0;
        else          cnt_reg <= cnt_next;
      end

      // A new tick beats a same-cycle grant clear, so the lane stays pending
      // and no overrun is counted for it.
      assign pending_next[gi] = (start_evt || over_evt) ? 1'b0 :
                                fire                    ? 1'b1 :
                                clr                     ? 1'b0 : pending_reg[gi];
      assign lane_ovr[gi]     = fire && pending_reg[gi] && !clr;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pending lane at or after ptr_reg
  // ---------------------------------------------------------------------------
  logic [LANE_W-1:0] sel_lane;
  logic              sel_found;
  logic [LANE_W:0]   cand;

  always_comb begin
    sel_lane  = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = {1'b0, ptr_reg} + (LANE_W+1)'(k);
      if (cand >= (LANE_W+1)'(NUM_LANES)) cand = cand - (LANE_W+1)'(NUM_LANES);
      if (!sel_found && pending_reg[LANE_W'(cand)]) begin
        sel_found = 1'b1;
        sel_lane  = LANE_W'(cand);
      end
    end
  end

  // New grants only from an idle port in RUN; an outstanding request survives
  // PAUSE but is withdrawn on game over.
  assign grant_ok = !valid_reg && is_run && sel_found && !over_evt;

  always_comb begin
    valid_next   = valid_reg;
    lane_next    = lane_reg;
    ptr_next     = ptr_reg;
    overrun_next = overrun_reg;

    if (start_evt || over_evt) valid_next = 1'b0;
    else if (accept)           valid_next = 1'b0;
    else if (grant_ok)         valid_next = 1'b1;

    if (grant_ok) lane_next = sel_lane;

    if (start_evt)   ptr_next = '0;
    else if (accept) ptr_next = (lane_reg == LANE_W'(NUM_LANES - 1)) ? '0 : (lane_reg + LANE_W'(1));

    if (start_evt)      overrun_next = 1'b0;
    else if (!over_evt) overrun_next = overrun_reg | (|lane_ovr);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg   <= ST_IDLE;
      presc_reg   <= '0;
      level_reg   <= '0;
      pending_reg <= '0;
      ptr_reg     <= '0;
      valid_reg   <= 1'b0;
      lane_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      level_reg   <= level_next;
      pending_reg <= pending_next;
      ptr_reg     <= ptr_next;
      valid_reg   <= valid_next;
      lane_reg    <= lane_next;
      overrun_reg <= overrun_next;
    end
  end

  assign o_Step_Valid = valid_reg;
  assign o_Step_Lane  = lane_reg;
  assign o_Level      = level_reg;
  assign o_State      = state_reg;
  assign o_Overrun    = overrun_reg;

endmodule

// File: tb/tb_lane_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lane_step_scheduler
//
// Drives lane_step_scheduler (3 lanes, prescale 4, base periods 2/3/4,
// STEP_DEC 1) with directed and $urandom stimulus. Every cycle, the outputs are
// compared against a behavioural game model that tracks absolute tick numbers
// and "next due tick" per lane.
// -----------------------------------------------------------------------------
module tb_lane_step_scheduler;

  localparam int NL = 3;
  localparam int PS = 4;
  localparam int LMAX = 7;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Start = 1'b0, i_Pause = 1'b0, i_Level_Up = 1'b0;
  logic       i_Game_Over = 1'b0, i_Step_Ready = 1'b0;
  logic       o_Step_Valid;
  logic [1:0] o_Step_Lane;
  logic [2:0] o_Level;
  logic [1:0] o_State;
  logic       o_Overrun;

  lane_step_scheduler #(
    .NUM_LANES    (NL),
    .PRESCALE     (PS),
    .PERIOD_W     (8),
    .c_BASE_PERIOD(24'h04_03_02),
    .LEVEL_W      (3),
    .STEP_DEC     (1),
    .MIN_PERIOD   (1)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Start     (i_Start),
    .i_Pause     (i_Pause),
    .i_Level_Up  (i_Level_Up),
    .i_Game_Over (i_Game_Over),
    .i_Step_Ready(i_Step_Ready),
    .o_Step_Valid(o_Step_Valid),
    .o_Step_Lane (o_Step_Lane),
    .o_Level     (o_Level),
    .o_State     (o_State),
    .o_Overrun   (o_Overrun)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  int base_p[NL] = '{2, 3, 4};
  int m_state, m_level, m_run_cyc, m_ticks, m_ptr, m_lane;
  bit m_valid, m_ovr;
  bit m_pend[NL];
  int m_next_fire[NL];

  function automatic int eff(int i, int lvl);
    int e;
    e = base_p[i] - lvl;
    return (e < 1) ? 1 : e;
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 0; m_run_cyc = 0; m_ticks = 0;
    m_ptr = 0; m_lane = 0; m_valid = 0; m_ovr = 0;
    for (int i = 0; i < NL; i++) begin
      m_pend[i] = 0;
      m_next_fire[i] = 0;
    end
  endtask

  task automatic model_step(input bit st, input bit pa, input bit lu, input bit go, input bit rdy);
    bit run, rp, io, start_e, over_e, tick, accept, grant;
    bit fire[NL];
    int n_lane, c;
    run = (m_state == 1);
    rp  = (m_state == 1) || (m_state == 2);
    io  = (m_state == 0) || (m_state == 3);
    over_e  = go && rp;
    start_e = st && !go && io;
    if (start_e) begin
      m_state = 1; m_level = 0; m_run_cyc = 0; m_ticks = 0;
      m_ptr = 0; m_valid = 0; m_ovr = 0;
      for (int i = 0; i < NL; i++) begin
        m_pend[i] = 0;
        m_next_fire[i] = eff(i, 0);
      end
      return;
    end
    tick   = run && ((m_run_cyc % PS) == PS - 1);
    accept = m_valid && rdy;
    for (int i = 0; i < NL; i++) fire[i] = tick && (m_ticks + 1 == m_next_fire[i]);
    grant = 0;
    n_lane = m_lane;
    if (!m_valid && run && !over_e) begin
      for (int k = 0; k < NL; k++) begin
        c = (m_ptr + k) % NL;
        if (!grant && m_pend[c]) begin
          grant = 1;
          n_lane = c;
        end
      end
    end
    // lane schedule
    for (int i = 0; i < NL; i++)
      if (fire[i]) m_next_fire[i] = m_ticks + 1 + eff(i, m_level);
    if (tick) m_ticks++;
    if (run) m_run_cyc++;
    // pending / overrun
    for (int i = 0; i < NL; i++) begin
      if (over_e) m_pend[i] = 0;
      else if (fire[i]) begin
        if (m_pend[i] && !(accept && m_lane == i)) m_ovr = 1;
        m_pend[i] = 1;
      end else if (accept && m_lane == i) m_pend[i] = 0;
    end
    if (accept) m_ptr = (m_lane + 1) % NL;
    if (over_e || accept) m_valid = 0;
    else if (grant) begin
      m_valid = 1;
      m_lane = n_lane;
    end
    if (lu && rp && m_level < LMAX) m_level++;
    case (m_state)
      1: if (over_e) m_state = 3; else if (pa) m_state = 2;
      2: if (over_e) m_state = 3; else if (!pa) m_state = 1;
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (o_State === 2'(m_state)) else begin
      failures++;
      $error("FAIL %s state got=%0d exp=%0d", tag, o_State, m_state);
    end
    checks++;
    assert (o_Level === 3'(m_level)) else begin
      failures++;
      $error("FAIL %s level got=%0d exp=%0d", tag, o_Level, m_level);
    end
    checks++;
    assert (o_Step_Valid === m_valid) else begin
      failures++;
      $error("FAIL %s valid got=%b exp=%b", tag, o_Step_Valid, m_valid);
    end
    checks++;
    assert (o_Overrun === m_ovr) else begin
      failures++;
      $error("FAIL %s overrun got=%b exp=%b", tag, o_Overrun, m_ovr);
    end
    if (m_valid) begin
      checks++;
      assert (o_Step_Lane === 2'(m_lane)) else begin
        failures++;
        $error("FAIL %s lane got=%0d exp=%0d", tag, o_Step_Lane, m_lane);
      end
    end
  endtask

  task automatic do_cycle(input bit st, input bit pa, input bit lu, input bit go, input bit rdy,
                          input string tag);
    i_Start = st; i_Pause = pa; i_Level_Up = lu; i_Game_Over = go; i_Step_Ready = rdy;
    model_step(st, pa, lu, go, rdy);
    @(posedge i_Clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert (o_Step_Valid === 1'b0 && o_State === 2'd0 && o_Level === 3'd0 && o_Overrun === 1'b0)
    else begin
      failures++;
      $error("FAIL %s valid/state/level/ovr got=%b/%0d/%0d/%b exp=0/0/0/0",
             tag, o_Step_Valid, o_State, o_Level, o_Overrun);
    end
  endtask

  task automatic wait_model_valid(input string tag);
    bit seen;
    seen = m_valid;
    for (int n = 0; n < 60 && !seen; n++) begin
      do_cycle(0, 0, 0, 0, 0, tag);
      seen = m_valid;
    end
    checks++;
    assert (seen) else begin
      failures++;
      $error("FAIL %s wait_valid got=timeout exp=valid within 60 clks", tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit pz;
    model_reset();
    @(posedge i_Clk);
    #1;
    check_zero("reset");
    i_Rst_L = 1'b1;

    // idle: Ready without Valid, Level_Up ignored
    for (int n = 0; n < 6; n++) do_cycle(0, 0, n[0], 0, 1'($urandom), "idle");

    // start; ready tied high
    do_cycle(1, 0, 0, 0, 1, "start");
    for (int n = 0; n < 100; n++) do_cycle(0, 0, 0, 0, 1, "ready1");
    for (int n = 0; n < 60; n++) do_cycle(0, 0, 0, 0, 1'($urandom), "readyrnd");

    // ready held low: request frozen, lane 0 re-ticks -> overrun
    for (int n = 0; n < 40; n++) do_cycle(0, 0, 0, 0, 0, "ready0");
    checks++;
    assert (o_Overrun === 1'b1) else begin
      failures++;
      $error("FAIL overrun_sticky got=%b exp=1", o_Overrun);
    end
    for (int n = 0; n < 30; n++) do_cycle(0, 0, 0, 0, 1, "release");

    // pause with an outstanding step
    wait_model_valid("pre_pause");
    for (int n = 0; n < 30; n++) do_cycle(0, 1, 0, 0, (n > 5), "pause");
    checks++;
    assert (o_State === 2'd2) else begin
      failures++;
      $error("FAIL pause_state got=%0d exp=2", o_State);
    end
    for (int n = 0; n < 40; n++) do_cycle(0, 0, 0, 0, 1, "resume");

    // level ups
    for (int p = 0; p < 3; p++) begin
      do_cycle(0, 0, 1, 0, 1, "lvlup");
      do_cycle(0, 0, 0, 0, 1, "lvlup");
    end
    for (int n = 0; n < 60; n++) do_cycle(0, 0, 0, 0, 1, "level3");
    for (int p = 0; p < 8; p++) do_cycle(0, 0, 1, 0, 1'($urandom), "lvlsat");
    checks++;
    assert (o_Level === 3'd7) else begin
      failures++;
      $error("FAIL level_sat got=%0d exp=7", o_Level);
    end
    for (int n = 0; n < 30; n++) do_cycle(0, 0, 0, 0, 1'($urandom), "level7");

    // game over with a step outstanding and Ready low
    wait_model_valid("pre_over");
    do_cycle(0, 0, 0, 1, 0, "gameover");
    checks++;
    assert (o_Step_Valid === 1'b0 && o_State === 2'd3) else begin
      failures++;
      $error("FAIL gameover_drop valid/state got=%b/%0d exp=0/3", o_Step_Valid, o_State);
    end
    for (int n = 0; n < 20; n++) do_cycle(0, 1'($urandom), 1'($urandom), 0, 1'($urandom), "over");
    do_cycle(1, 0, 0, 0, 1, "restart");
    checks++;
    assert (o_State === 2'd1 && o_Level === 3'd0) else begin
      failures++;
      $error("FAIL restart state/level got=%0d/%0d exp=1/0", o_State, o_Level);
    end
    for (int n = 0; n < 20; n++) do_cycle(0, 0, 0, 0, 1, "after_restart");

    // fully random mix
    pz = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(15) == 0) pz = !pz;
      do_cycle($urandom_range(31) == 0, pz, $urandom_range(15) == 0,
               $urandom_range(79) == 0, 1'($urandom), "random");
    end

    // asynchronous reset in the middle of a grant
    if (m_state != 1) do_cycle(1, 0, 0, 0, 0, "pre_rst_start");
    wait_model_valid("pre_rst");
    #2;
    i_Rst_L = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge i_Clk);
    #1;
    check_outputs("rst_hold");
    i_Rst_L = 1'b1;
    do_cycle(1, 0, 0, 0, 1, "post_rst_start");
    checks++;
    assert (o_State === 2'd1) else begin
      failures++;
      $error("FAIL post_rst_state got=%0d exp=1", o_State);
    end
    for (int n = 0; n < 40; n++) do_cycle(0, 0, 0, 0, 1'($urandom), "tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
